// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the clear-engine state encoding
// used by the general-purpose register bank.
package cpu_pkg;

   localparam int WORD_W  = 16;
   localparam int NUM_GPR = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port of the register bank: range check,
// hard-wired zero entry and same-cycle write bypass.
module reg_file_rd_port
   import cpu_pkg::*;
#(
   parameter int WIDTH   = WORD_W,
   parameter int DEPTH   = NUM_GPR,
   parameter int AW      = $clog2(DEPTH),
   parameter int BYPASS  = 1,
   parameter int ZERO_R0 = 0
) (
   input  logic [WIDTH-1:0] i_mem [DEPTH],
   input  logic [AW-1:0]    i_raddr,
   input  logic             i_wr_acc,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic w_in_range;
   logic w_is_zero;
   logic w_hit;

   assign w_in_range = ({1'b0, i_raddr} < DEPTH_C);
   assign w_is_zero  = (ZERO_R0 != 0) && (i_raddr == '0);
   // i_wr_acc already excludes dropped writes, so no range/R0 recheck here
   assign w_hit      = (BYPASS != 0) && i_wr_acc && (i_raddr == i_waddr);

   // The array is only indexed once the address is known to be in range
   always_comb begin
      o_rdata = '0;
      if (w_in_range && !w_is_zero) begin
         if (w_hit) begin
            o_rdata = i_wdata;
         end else begin
            o_rdata = i_mem[i_raddr];
         end
      end
   end

endmodule

// File: rtl/reg_file.sv
// General-purpose register bank: DEPTH x WIDTH entries, two combinational
// read ports, one write port and a one-entry-per-cycle clear engine.
module reg_file
   import cpu_pkg::*;
#(
   parameter  int WIDTH   = WORD_W,
   parameter  int DEPTH   = NUM_GPR,
   parameter  int BYPASS  = 1,
   parameter  int ZERO_R0 = 0,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_a_i,
   output logic [WIDTH-1:0] rdata_a_o,
   input  logic [AW-1:0]    raddr_b_i,
   output logic [WIDTH-1:0] rdata_b_o,
   input  logic             clr_i,
   output logic             busy_o
);

   localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   clr_state_t       r_state;
   clr_state_t       w_state_nxt;
   logic [AW-1:0]    r_idx;
   logic [AW-1:0]    w_idx_nxt;
   logic             w_waddr_ok;
   logic             w_wr_acc;

   assign w_waddr_ok = ({1'b0, waddr_i} < DEPTH_C) &&
                       !((ZERO_R0 != 0) && (waddr_i == '0));
   // Writes are only taken in IDLE; anything issued during a sweep is dropped
   assign w_wr_acc   = we_i && (r_state == ST_IDLE) && w_waddr_ok;
   assign busy_o     = (r_state == ST_CLEAR);

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      case (r_state)
         ST_IDLE: begin
            if (clr_i) begin
               w_state_nxt = ST_CLEAR;
               w_idx_nxt   = '0;
            end
         end
         ST_CLEAR: begin
            if (r_idx == LAST_IDX) begin
               w_state_nxt = ST_IDLE;
               w_idx_nxt   = '0;
            end else begin
               w_idx_nxt   = r_idx + AW'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // r_idx never exceeds DEPTH-1 while in CLEAR, so the sweep index is safe
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (r_state == ST_CLEAR) begin
         r_mem[r_idx] <= '0;
      end else if (w_wr_acc) begin
         r_mem[waddr_i] <= wdata_i;
      end
   end

   reg_file_rd_port #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .AW      (AW),
      .BYPASS  (BYPASS),
      .ZERO_R0 (ZERO_R0)
   ) u_rd_a (
      .i_mem    (r_mem),
      .i_raddr  (raddr_a_i),
      .i_wr_acc (w_wr_acc),
      .i_waddr  (waddr_i),
      .i_wdata  (wdata_i),
      .o_rdata  (rdata_a_o)
   );

   reg_file_rd_port #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .AW      (AW),
      .BYPASS  (BYPASS),
      .ZERO_R0 (ZERO_R0)
   ) u_rd_b (
      .i_mem    (r_mem),
      .i_raddr  (raddr_b_i),
      .i_wr_acc (w_wr_acc),
      .i_waddr  (waddr_i),
      .i_wdata  (wdata_i),
      .o_rdata  (rdata_b_o)
   );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: four configurations share one stimulus stream
// (default, no bypass, zero entry 0, six entries).
module tb_reg_file;

   logic        clk;
   logic        reset;
   logic        we;
   logic        clr;
   logic [2:0]  waddr;
   logic [15:0] wdata;
   logic [2:0]  ra;
   logic [2:0]  rb;

   logic [15:0] a0, b0, a1, b1, a2, b2, a3, b3;
   logic        busy0, busy1, busy2, busy3;

   int n_cmp = 0;
   int n_err = 0;

   reg_file #(.WIDTH(16), .DEPTH(8), .BYPASS(1), .ZERO_R0(0)) dut (
      .clk(clk), .reset(reset), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
      .raddr_a_i(ra), .rdata_a_o(a0), .raddr_b_i(rb), .rdata_b_o(b0),
      .clr_i(clr), .busy_o(busy0));

   reg_file #(.WIDTH(16), .DEPTH(8), .BYPASS(0), .ZERO_R0(0)) dut_nb (
      .clk(clk), .reset(reset), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
      .raddr_a_i(ra), .rdata_a_o(a1), .raddr_b_i(rb), .rdata_b_o(b1),
      .clr_i(clr), .busy_o(busy1));

   reg_file #(.WIDTH(16), .DEPTH(8), .BYPASS(1), .ZERO_R0(1)) dut_z (
      .clk(clk), .reset(reset), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
      .raddr_a_i(ra), .rdata_a_o(a2), .raddr_b_i(rb), .rdata_b_o(b2),
      .clr_i(clr), .busy_o(busy2));

   reg_file #(.WIDTH(16), .DEPTH(6), .BYPASS(1), .ZERO_R0(0)) dut_d6 (
      .clk(clk), .reset(reset), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
      .raddr_a_i(ra), .rdata_a_o(a3), .raddr_b_i(rb), .rdata_b_o(b3),
      .clr_i(clr), .busy_o(busy3));

   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef struct {
      logic        we;
      logic [2:0]  waddr;
      logic [15:0] wdata;
      logic [2:0]  ra;
      logic [2:0]  rb;
      logic [15:0] exp_a;    // BYPASS=1 instance
      logic [15:0] exp_b;
      logic [15:0] exp_na;   // BYPASS=0 instance
      logic [15:0] exp_nb;
   } vec_t;

   vec_t vecs [7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   initial begin
      int cnt0;
      int cnt3;

      vecs[0] = '{1'b1, 3'd3, 16'hA5A5, 3'd3, 3'd0, 16'hA5A5, 16'h0000, 16'h0000, 16'h0000};
      vecs[1] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5};
      vecs[2] = '{1'b1, 3'd7, 16'h1234, 3'd7, 3'd6, 16'h1234, 16'h0000, 16'h0000, 16'h0000};
      vecs[3] = '{1'b1, 3'd0, 16'h00FF, 3'd7, 3'd0, 16'h1234, 16'h00FF, 16'h1234, 16'h0000};
      vecs[4] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd3, 16'h00FF, 16'hA5A5, 16'h00FF, 16'hA5A5};
      vecs[5] = '{1'b1, 3'd3, 16'h5A5A, 3'd3, 3'd3, 16'h5A5A, 16'h5A5A, 16'hA5A5, 16'hA5A5};
      vecs[6] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd7, 16'h5A5A, 16'h1234, 16'h5A5A, 16'h1234};

      reset = 1'b1; we = 1'b0; clr = 1'b0; waddr = '0; wdata = '0; ra = '0; rb = '0;
      tick();
      tick();

      // Reset overrides a simultaneous write
      we = 1'b1; waddr = 3'd4; wdata = 16'h4444;
      tick();
      reset = 1'b0; we = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ra = 3'(i); rb = 3'(i);
         #1;
         check("rst_rd_a", a0, 16'h0000);
         check("rst_rd_b", b0, 16'h0000);
      end
      check("rst_busy", 16'(busy0), 16'h0000);
      check("rst_busy_d6", 16'(busy3), 16'h0000);

      // Table of write/read/bypass vectors
      for (int v = 0; v < 7; v++) begin
         we = vecs[v].we; waddr = vecs[v].waddr; wdata = vecs[v].wdata;
         ra = vecs[v].ra; rb = vecs[v].rb;
         #1;
         check($sformatf("vec%0d_a", v), a0, vecs[v].exp_a);
         check($sformatf("vec%0d_b", v), b0, vecs[v].exp_b);
         check($sformatf("vec%0d_nb_a", v), a1, vecs[v].exp_na);
         check($sformatf("vec%0d_nb_b", v), b1, vecs[v].exp_nb);
         tick();
      end
      we = 1'b0;

      // Fill, then sweep
      for (int i = 0; i < 8; i++) begin
         we = 1'b1; waddr = 3'(i); wdata = 16'h1000 + 16'(i);
         tick();
      end
      we = 1'b0;
      ra = 3'd5; rb = 3'd6; #1;
      check("d6_rd5", a3, 16'h1005);
      check("d6_rd6", b3, 16'h0000);
      ra = 3'd7; rb = 3'd0; #1;
      check("d6_rd7", a3, 16'h0000);
      check("z_rd0", b2, 16'h0000);
      check("z_rd7", a2, 16'h1007);

      clr = 1'b1;
      tick();
      clr = 1'b0;
      cnt0 = 0; cnt3 = 0;
      for (int k = 0; k < 12; k++) begin
         if (busy0) cnt0++;
         if (busy3) cnt3++;
         if (k == 0) check("clr_busy_k0", 16'(busy0), 16'h0001);
         if (k == 2) begin
            we = 1'b1; waddr = 3'd5; wdata = 16'hDEAD; ra = 3'd5;
            #1;
            check("busy_no_bypass", a0, 16'h1005);
         end
         if (k == 4) begin
            for (int i = 0; i < 8; i++) begin
               ra = 3'(i); rb = 3'(i);
               #1;
               check($sformatf("mid_a%0d", i), a0, (i < 4) ? 16'h0000 : 16'h1000 + 16'(i));
               check($sformatf("mid_b%0d", i), b0, (i < 4) ? 16'h0000 : 16'h1000 + 16'(i));
            end
         end
         tick();
         we = 1'b0;
      end
      check("busy_cycles_d8", 16'(cnt0), 16'd8);
      check("busy_cycles_d6", 16'(cnt3), 16'd6);
      for (int i = 0; i < 8; i++) begin
         ra = 3'(i); rb = 3'(i);
         #1;
         check($sformatf("post_clr_a%0d", i), a0, 16'h0000);
         check($sformatf("post_clr_d6_%0d", i), a3, 16'h0000);
      end

      // Write with clear in the same cycle, then reset mid-sweep
      for (int i = 0; i < 8; i++) begin
         we = 1'b1; waddr = 3'(i); wdata = 16'h2000 + 16'(i);
         tick();
      end
      clr = 1'b1; we = 1'b1; waddr = 3'd2; wdata = 16'hBEEF; ra = 3'd2;
      #1;
      check("clrwe_bypass", a0, 16'hBEEF);
      tick();
      clr = 1'b0; we = 1'b0;
      check("clrwe_busy", 16'(busy0), 16'h0001);
      check("clrwe_landed", a0, 16'hBEEF);
      tick();
      tick();
      ra = 3'd0; rb = 3'd7; #1;
      check("sweep3_rd0", a0, 16'h0000);
      check("sweep3_rd7", b0, 16'h2007);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_busy", 16'(busy0), 16'h0000);
      for (int i = 0; i < 8; i++) begin
         ra = 3'(i); rb = 3'(i);
         #1;
         check($sformatf("abort_a%0d", i), a0, 16'h0000);
         check($sformatf("abort_b%0d", i), b0, 16'h0000);
      end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("reclr_busy", 16'(busy0), 16'h0001);
      for (int k = 0; k < 12 && busy0; k++) tick();
      check("reclr_done", 16'(busy0), 16'h0000);

      // Hard-wired zero entry
      we = 1'b1; waddr = 3'd0; wdata = 16'hFFFF; ra = 3'd0;
      #1;
      check("z_w0_nobypass", a2, 16'h0000);
      check("def_w0_bypass", a0, 16'hFFFF);
      tick();
      we = 1'b0; #1;
      check("z_w0_read", a2, 16'h0000);
      check("def_w0_read", a0, 16'hFFFF);
      we = 1'b1; waddr = 3'd1; wdata = 16'h1111; ra = 3'd1;
      #1;
      check("z_w1_bypass", a2, 16'h1111);
      tick();

      // Out-of-range write on the six-entry bank
      we = 1'b1; waddr = 3'd6; wdata = 16'h6666; ra = 3'd6; rb = 3'd6;
      #1;
      check("d6_oor_nobypass", a3, 16'h0000);
      check("def_rd6_bypass", b0, 16'h6666);
      tick();
      we = 1'b0; #1;
      check("d6_oor_read", a3, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
